// File: rtl/ctr_retire_sync.sv
// Pairs retire events from two lock-stepped cores into one aligned strobe.
// Optional opcode cross-check: define CTR_RETIRE_SYNC_OPCODE_CHECK_EN.
module ctr_retire_sync #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        retire_1_i,
  input  logic [31:0] instr_1_i,
  input  logic        retire_2_i,
  input  logic [31:0] instr_2_i,
  input  logic        flush_i,
  output logic        retire_o,
  output logic [31:0] instr_1_o,
  output logic [31:0] instr_2_o,
  output logic        stall_1_o,
  output logic        stall_2_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic        mismatch_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);
  localparam logic [SW-1:0] TMAX   = SW'(TIMEOUT);
  localparam logic [SW-1:0] S1     = SW'(1);
  localparam logic [PW-1:0] P1     = PW'(1);

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem1_q [DEPTH];
  logic [31:0] mem2_q [DEPTH];

  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] cnt2_q, cnt2_d;
  logic [PW-1:0] wp1_q, wp1_d;
  logic [PW-1:0] wp2_q, wp2_d;
  logic [PW-1:0] rp1_q, rp1_d;
  logic [PW-1:0] rp2_q, rp2_d;
  logic [SW-1:0] skew_q, skew_d;

  logic        retire_q, retire_d;
  logic [31:0] instr1_q, instr1_d;
  logic [31:0] instr2_q, instr2_d;
  logic        stall1_q, stall1_d;
  logic        stall2_q, stall2_d;
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;

  logic        ne1, ne2, pop;
  logic        push1, push2;
  logic        ovf1, ovf2;
  logic        mm_hit;
  logic [31:0] head1, head2;

  assign ne1   = (cnt1_q != '0);
  assign ne2   = (cnt2_q != '0);
  assign pop   = ne1 && ne2;
  assign head1 = mem1_q[rp1_q];
  assign head2 = mem2_q[rp2_q];

`ifdef CTR_RETIRE_SYNC_OPCODE_CHECK_EN
  logic mismatch_q, mismatch_d;

  assign mm_hit = pop && (head1[6:0] != head2[6:0]);

  // Latch an opcode disagreement seen on a pairing in RUN.
  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == RUN && !flush_i && mm_hit) begin
      mismatch_d = 1'b1;
    end
  end

  // Sticky mismatch flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_o = mismatch_q;
`else
  assign mm_hit     = 1'b0;
  assign mismatch_o = 1'b0;
`endif

  // Next-state: pushes, pairing pops, skew tracking and error entry.
  always_comb begin
    state_d    = state_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    wp1_d      = wp1_q;
    wp2_d      = wp2_q;
    rp1_d      = rp1_q;
    rp2_d      = rp2_q;
    skew_d     = skew_q;
    retire_d   = 1'b0;
    instr1_d   = instr1_q;
    instr2_d   = instr2_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    push1      = 1'b0;
    push2      = 1'b0;
    ovf1       = 1'b0;
    ovf2       = 1'b0;
    if (state_q == RUN) begin
      if (flush_i) begin
        cnt1_d = '0;
        cnt2_d = '0;
        wp1_d  = '0;
        wp2_d  = '0;
        rp1_d  = '0;
        rp2_d  = '0;
        skew_d = '0;
      end else begin
        push1 = retire_1_i && (cnt1_q != FULL || pop);
        push2 = retire_2_i && (cnt2_q != FULL || pop);
        ovf1  = retire_1_i && (cnt1_q == FULL) && !pop;
        ovf2  = retire_2_i && (cnt2_q == FULL) && !pop;
        if (pop) begin
          rp1_d    = rp1_q + P1;
          rp2_d    = rp2_q + P1;
          retire_d = 1'b1;
          instr1_d = head1;
          instr2_d = head2;
        end
        if (push1) wp1_d = wp1_q + P1;
        if (push2) wp2_d = wp2_q + P1;
        cnt1_d = cnt1_q + CW'(push1) - CW'(pop);
        cnt2_d = cnt2_q + CW'(push2) - CW'(pop);
        if (ne1 ^ ne2) begin
          skew_d = (skew_q == TMAX) ? TMAX : skew_q + S1;
        end else begin
          skew_d = '0;
        end
        if (ovf1 || ovf2) overflow_d = 1'b1;
        if (skew_d == TMAX) timeout_d = 1'b1;
        if (ovf1 || ovf2 || skew_d == TMAX || mm_hit) begin
          state_d = ERR;
        end
      end
    end
    stall1_d = (state_d == ERR) || (cnt1_d >= ALMOST);
    stall2_d = (state_d == ERR) || (cnt2_d >= ALMOST);
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      wp1_q      <= '0;
      wp2_q      <= '0;
      rp1_q      <= '0;
      rp2_q      <= '0;
      skew_q     <= '0;
      retire_q   <= 1'b0;
      instr1_q   <= '0;
      instr2_q   <= '0;
      stall1_q   <= 1'b0;
      stall2_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      wp1_q      <= wp1_d;
      wp2_q      <= wp2_d;
      rp1_q      <= rp1_d;
      rp2_q      <= rp2_d;
      skew_q     <= skew_d;
      retire_q   <= retire_d;
      instr1_q   <= instr1_d;
      instr2_q   <= instr2_d;
      stall1_q   <= stall1_d;
      stall2_q   <= stall2_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage; only accepted pushes write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1_q[i] <= '0;
        mem2_q[i] <= '0;
      end
    end else begin
      if (push1) mem1_q[wp1_q] <= instr_1_i;
      if (push2) mem2_q[wp2_q] <= instr_2_i;
    end
  end

  assign retire_o   = retire_q;
  assign instr_1_o  = instr1_q;
  assign instr_2_o  = instr2_q;
  assign stall_1_o  = stall1_q;
  assign stall_2_o  = stall2_q;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

endmodule

// File: doc/ctr_retire_sync.md
Name: ctr_retire_sync

Overview:
Pairs retirement events from two lock-stepped core copies (execution 1 and execution 2) so the contract checker sees one aligned retire strobe with both instruction words.
- Each core retires independently; per-core FIFOs absorb the skew and pop in program order.
- Each pairing produces a single registered retire_o pulse, which feeds the checker's retire input.
- Detects loss of alignment (FIFO overflow, excessive skew) and freezes in a sticky error state.

Parameters:
DEPTH, 4, entries per per-core FIFO; power of two, >= 2
TIMEOUT, 64, maximum cycles one FIFO may hold entries while the other is empty; >= 1

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
retire_1_i  input  1  core 1 retires instr_1_i this cycle
instr_1_i  input  32  core 1 retired instruction word
retire_2_i  input  1  core 2 retires instr_2_i this cycle
instr_2_i  input  32  core 2 retired instruction word
flush_i  input  1  synchronous flush of both FIFOs and the skew counter
retire_o  output  1  one-cycle paired retire strobe to the checker
instr_1_o  output  32  paired core 1 instruction, valid while retire_o=1
instr_2_o  output  32  paired core 2 instruction, valid while retire_o=1
stall_1_o  output  1  core 1 FIFO almost full; hold core 1
stall_2_o  output  1  core 2 FIFO almost full; hold core 2
overflow_o  output  1  sticky: a push arrived while its FIFO was full
timeout_o  output  1  sticky: skew limit exceeded
mismatch_o  output  1  sticky: opcode mismatch (optional feature)

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0, including instr_*_o.
  - FIFO counts, pointers and skew counter 0; state RUN.
  - Reset mid-operation discards all queued entries.
- Widths: count_k is $clog2(DEPTH+1) bits; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; skew counter is $clog2(TIMEOUT+1) bits and saturates.
- States: RUN and ERR. ERR is left only by reset.
- Push (RUN): retire_k_i=1 with count_k<DEPTH writes instr_k_i at the write pointer at the clock edge.
- Overflow: retire_k_i=1 with count_k==DEPTH:
  - entry dropped;
  - overflow_o<=1, state<=ERR.
- Pairing (RUN): when count_1>0 and count_2>0 at the start of a cycle:
  - pop both heads at that edge;
  - retire_o<=1 and instr_1_o/instr_2_o<=heads.
  - Otherwise retire_o<=0 and instr_*_o hold their last value.
- Latency: retire_k_i in cycle t with both FIFOs previously empty gives retire_o=1 in cycle t+2, counted from the later of the two retire pulses.
- Throughput: one pair per cycle. Push and pop on the same FIFO in the same cycle leaves its count unchanged, and is legal even when full.
- stall_k_o = (count_k >= DEPTH-1), registered from the next-state count.
- Skew counter:
  - increments each cycle exactly one FIFO is non-empty;
  - clears when both are empty or both are non-empty.
  - Reaching TIMEOUT sets timeout_o<=1 and state<=ERR.
- ERR:
  - pushes ignored; no pops; retire_o=0;
  - stall_1_o=stall_2_o=1;
  - sticky flags hold.
- flush_i=1 in RUN:
  - counts, pointers and skew counter go to 0; retire_o<=0.
  - Same-cycle retires are dropped (flush wins).
  - No effect in ERR; does not clear sticky flags.
- Simultaneous overflow and timeout in the same cycle set both flags.

Optional Feature:
CTR_RETIRE_SYNC_OPCODE_CHECK_EN
- Defined: at each pairing, compare head_1[6:0] with head_2[6:0]. On inequality:
  - the pair is still emitted on retire_o;
  - mismatch_o<=1 and state<=ERR from the next cycle.
- Undefined: mismatch_o tied 0; no comparator is built.

Test Plan:
1. Both FIFOs empty; retire_1_i=retire_2_i=1 in cycle 5 with instr 0x00000013 -> retire_o=1 only in cycle 7; instr_1_o=instr_2_o=0x00000013.
2. DEPTH=4: core 1 retires 0x00100093, 0x00200113, 0x00300193 in cycles 0-2; core 2 retires the same words in cycles 6-8 -> stall_1_o=1 once count_1=3; retire_o pulses in cycles 8, 9, 10 in order; TIMEOUT=64 not hit.
3. DEPTH=4: core 1 retires 5 words back-to-back; core 2 is silent -> overflow_o=1 after the 5th push; later core 2 retires produce no retire_o; stall_*_o=1.
4. TIMEOUT=8: a single core 1 retire, core 2 silent -> timeout_o rises after 8 skew cycles; ERR is held until rst_ni=0, after which all outputs are 0.
5. count_1=2; flush_i=1 with retire_1_i=1 in the same cycle -> count_1=0, no retire_o; a following paired retire gives the normal 2-cycle latency.
6. With CTR_RETIRE_SYNC_OPCODE_CHECK_EN: pair 0x00000013 with 0x00000033 -> retire_o=1 once, mismatch_o=1 the next cycle, no further retire_o. Without the macro, the same stimulus keeps mismatch_o=0.
